pll_lock_sequencer: RTL
=======================

Name: pll_lock_sequencer

Overview:
- Controls the SWIPT PLL loop: loads the default drive frequency, releases the PLL once the heartbeat is alive, gear-shifts the loop coefficient from fast to slow, and declares lock.
- Clamps PLL phase output before it reaches the SwiptOut frequency input.
- Handles heartbeat loss, acquisition timeout and loss of lock.
- Sits between PLL (phase/error in; load_freq/lgcoefficient out) and SwiptOut (freq in).

Parameters:
- FREQ_DEFAULT, 32'h9C40, frequency word driven after reset and on every reload
- FREQ_MIN, 32'h8000, lower clamp for freq_out
- FREQ_MAX, 32'hC000, upper clamp for freq_out
- LG_FAST, 5'd8, lgcoefficient at start of acquisition
- LG_SLOW, 5'd16, final tracking lgcoefficient; LG_FAST <= LG_SLOW required
- GEAR_CNT, 16'd64, consecutive in-phase cycles per gear step
- LOCK_CNT, 16'd256, consecutive in-phase cycles at LG_SLOW to declare lock
- UNLOCK_CNT, 8'd16, consecutive bad-error cycles in TRACK to drop lock
- ACQ_TIMEOUT, 24'd1000000, ACQUIRE cycle budget per attempt
- MAX_RETRY, 3'd3, acquisition attempts before FAULT
- LOAD_CYCLES, 4'd4, cycles load_freq is held high in LOAD

Ports:
- clk  in  1  system clock
- nrst  in  1  reset, synchronous, active-low
- swiptAlive  in  1  heartbeat-valid from Heartbeat
- pll_phase  in  32  PLL frequency/phase word
- pll_error  in  2  PLL phase detector: 00 in phase, 01 lead, 10 lag, 11 invalid
- freq_out  out  32  frequency word to SwiptOut and PLL freq input
- load_freq  out  1  PLL load strobe; high forces PLL to load freq_out
- lgcoefficient  out  5  PLL loop gain shift
- locked  out  1  loop locked
- fault  out  1  sticky acquisition failure
- state  out  3  current FSM state (debug)

Behaviour:
- Reset (nrst=0 at posedge clk): state=IDLE, freq_out=FREQ_DEFAULT, load_freq=1, lgcoefficient=LG_FAST, locked=0, fault=0, all counters 0, retry=0.
- States/encoding: IDLE=0, LOAD=1, ACQUIRE=2, TRACK=3, HOLD=4, FAULT=5.
- Good cycle: pll_error==00. Bad cycle: any other value; 11 is bad in every state.
- IDLE: load_freq=1, freq_out=FREQ_DEFAULT. swiptAlive=1 -> LOAD next cycle.
- LOAD: load_freq=1, freq_out=FREQ_DEFAULT, lgcoefficient=LG_FAST, run/timeout counters cleared. After exactly LOAD_CYCLES cycles in LOAD -> ACQUIRE.
- ACQUIRE: load_freq=0. freq_out <= clamp(pll_phase) every cycle, registered with 1-cycle latency. clamp(x): x<FREQ_MIN -> FREQ_MIN; x>FREQ_MAX -> FREQ_MAX; otherwise x (unsigned).
  - run counter increments on good cycles and clears on bad cycles.
  - If lgcoefficient<LG_SLOW and run==GEAR_CNT-1 on a good cycle: lgcoefficient+1, run=0.
  - If lgcoefficient==LG_SLOW and run==LOCK_CNT-1 on a good cycle: -> TRACK, locked=1 in the same update.
  - Timeout counter increments every cycle. On reaching ACQ_TIMEOUT-1: retry+1; if new retry==MAX_RETRY -> FAULT, else -> LOAD. Timeout has priority over lock in the same cycle.
- TRACK: load_freq=0, lgcoefficient=LG_SLOW, freq_out <= clamp(pll_phase).
  - bad counter increments on bad cycles and clears on good cycles.
  - On reaching UNLOCK_CNT: locked=0, retry=0 -> LOAD.
- HOLD: entered from LOAD/ACQUIRE/TRACK whenever swiptAlive=0. Takes priority over every other transition.
  - freq_out frozen; load_freq=1; locked=0; counters frozen.
  - swiptAlive=1 -> LOAD; retry is not cleared.
- FAULT: freq_out=FREQ_DEFAULT, load_freq=1, locked=0, fault=1. Exits only via nrst=0; ignores swiptAlive.
- nrst=0 mid-operation from any state: full reset values on the next edge.
- Counter widths are wide enough that they never wrap before their terminal compare.

Optional Feature:
- Macro PLL_LOCK_STATS_EN.
- Defined: adds output lock_loss_cnt[15:0]. Cleared on reset; increments on each TRACK->LOAD and each TRACK->HOLD transition; saturates at 16'hFFFF.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan (sim params: GEAR_CNT=4, LOCK_CNT=8, UNLOCK_CNT=3, ACQ_TIMEOUT=100, MAX_RETRY=2, LG_FAST=14, LG_SLOW=16):
- Reset, swiptAlive=1, pll_error=00 constant -> LOAD held for 4 cycles. Then lgcoefficient 14->15->16 at 4-cycle intervals; locked=1 exactly 8 good cycles after reaching 16.
- In ACQUIRE, pll_phase=32'h7000 -> freq_out=32'h8000; pll_phase=32'hD000 -> freq_out=32'hC000; pll_phase=32'hA000 -> freq_out=32'hA000 one cycle later.
- Locked, then pll_error=10 for 3 cycles -> locked=0, state=LOAD, load_freq=1. With only 2 bad cycles followed by 00, lock is kept.
- pll_error=01 forever after swiptAlive=1 -> two 100-cycle timeouts, then state=FAULT, fault=1, freq_out=32'h9C40. fault stays set through swiptAlive toggles until nrst=0.
- swiptAlive drops while locked with freq_out=32'hA123 -> HOLD, freq_out stays 32'hA123, load_freq=1; swiptAlive returns -> LOAD, freq_out=32'h9C40.
- With PLL_LOCK_STATS_EN defined: two lock losses (one via error, one via swiptAlive) -> lock_loss_cnt=2; after nrst=0, lock_loss_cnt=0.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//    Sequences the PLL loop. It loads the default drive frequency, releases the
//    PLL once the heartbeat is alive, and gear-shifts the loop coefficient from
//    fast to slow before declaring lock. It also clamps the PLL phase word
//    before that word drives the SwiptOut frequency input.
//
// Ports:
//    clk            system clock
//    nrst           synchronous active-low reset
//    swiptAlive     heartbeat valid
//    pll_phase      PLL frequency/phase word
//    pll_error      phase detector: 00 in phase, 01 lead, 10 lag, 11 invalid
//    freq_out       clamped frequency word to SwiptOut / PLL
//    load_freq      PLL load strobe
//    lgcoefficient  PLL loop gain shift
//    locked         loop locked
//    fault          sticky acquisition failure
//    state          current FSM state (debug)
//    lock_loss_cnt  saturating count of lock losses (only with PLL_LOCK_STATS_EN)
//
// Optional feature macro: PLL_LOCK_STATS_EN
//
// state   | meaning
// IDLE    | after reset, waiting for heartbeat
// LOAD    | PLL held in load with default frequency for LOAD_CYCLES
// ACQUIRE | loop running, coefficient gear-shifted toward LG_SLOW
// TRACK   | locked, watching for sustained phase error
// HOLD    | heartbeat lost, outputs frozen
// FAULT   | retries exhausted, sticky until reset
module pll_lock_sequencer #(
   parameter logic [31:0] FREQ_DEFAULT = 32'h9C40,
   parameter logic [31:0] FREQ_MIN     = 32'h8000,
   parameter logic [31:0] FREQ_MAX     = 32'hC000,
   parameter logic [4:0]  LG_FAST      = 5'd8,
   parameter logic [4:0]  LG_SLOW      = 5'd16,
   parameter logic [15:0] GEAR_CNT     = 16'd64,
   parameter logic [15:0] LOCK_CNT     = 16'd256,
   parameter logic [7:0]  UNLOCK_CNT   = 8'd16,
   parameter logic [23:0] ACQ_TIMEOUT  = 24'd1000000,
   parameter logic [2:0]  MAX_RETRY    = 3'd3,
   parameter logic [3:0]  LOAD_CYCLES  = 4'd4
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        swiptAlive,
   input  logic [31:0] pll_phase,
   input  logic [1:0]  pll_error,
   output logic [31:0] freq_out,
   output logic        load_freq,
   output logic [4:0]  lgcoefficient,
   output logic        locked,
   output logic        fault,
   output logic [2:0]  state
`ifdef PLL_LOCK_STATS_EN
   ,
   output logic [15:0] lock_loss_cnt
`endif
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_ACQUIRE = 3'd2,
      S_TRACK   = 3'd3,
      S_HOLD    = 3'd4,
      S_FAULT   = 3'd5
   } state_t;

   state_t      cur_state, nxt_state;
   logic [15:0] run_cnt, nxt_run;
   logic [23:0] to_cnt, nxt_to;
   logic [7:0]  bad_cnt, nxt_bad;
   logic [2:0]  retry, nxt_retry, retry_inc;
   logic [3:0]  load_cnt, nxt_load;
   logic [31:0] nxt_freq, phase_clamped;
   logic [4:0]  nxt_lg;
   logic        nxt_locked, nxt_fault, good;

   assign good      = (pll_error == 2'b00);
   assign retry_inc = retry + 3'd1;
   assign state     = cur_state;

   always_comb begin
      if (pll_phase < FREQ_MIN)
         phase_clamped = FREQ_MIN;
      else if (pll_phase > FREQ_MAX)
         phase_clamped = FREQ_MAX;
      else
         phase_clamped = pll_phase;
   end

   always_comb begin
      nxt_state  = cur_state;
      nxt_freq   = freq_out;
      nxt_lg     = lgcoefficient;
      nxt_locked = locked;
      nxt_fault  = fault;
      nxt_run    = run_cnt;
      nxt_to     = to_cnt;
      nxt_bad    = bad_cnt;
      nxt_retry  = retry;
      nxt_load   = load_cnt;
      load_freq  = 1'b1;

      case (cur_state)
         S_IDLE: begin
            if (swiptAlive)
               nxt_state = S_LOAD;
         end
         S_LOAD: begin
            if (!swiptAlive)
               nxt_state = S_HOLD;
            else if (load_cnt == LOAD_CYCLES - 4'd1) begin
               nxt_state = S_ACQUIRE;
               nxt_load  = 4'd0;
            end else
               nxt_load = load_cnt + 4'd1;
         end
         S_ACQUIRE: begin
            load_freq = 1'b0;
            if (!swiptAlive)
               nxt_state = S_HOLD;
            else begin
               nxt_to   = to_cnt + 24'd1;
               nxt_freq = phase_clamped;
               nxt_run  = good ? run_cnt + 16'd1 : 16'd0;
               if (good && (lgcoefficient < LG_SLOW) && (run_cnt == GEAR_CNT - 16'd1)) begin
                  nxt_lg  = lgcoefficient + 5'd1;
                  nxt_run = 16'd0;
               end
               if (good && (lgcoefficient == LG_SLOW) && (run_cnt == LOCK_CNT - 16'd1)) begin
                  nxt_state  = S_TRACK;
                  nxt_locked = 1'b1;
               end
               // timeout overrides a lock landing on the same cycle
               if (to_cnt == ACQ_TIMEOUT - 24'd1) begin
                  nxt_retry = retry_inc;
                  nxt_state = (retry_inc == MAX_RETRY) ? S_FAULT : S_LOAD;
               end
            end
         end
         S_TRACK: begin
            load_freq = 1'b0;
            if (!swiptAlive)
               nxt_state = S_HOLD;
            else begin
               nxt_freq = phase_clamped;
               nxt_lg   = LG_SLOW;
               if (good)
                  nxt_bad = 8'd0;
               else if (bad_cnt == UNLOCK_CNT - 8'd1) begin
                  nxt_state = S_LOAD;
                  nxt_retry = 3'd0;
               end else
                  nxt_bad = bad_cnt + 8'd1;
            end
         end
         S_HOLD: begin
            if (swiptAlive)
               nxt_state = S_LOAD;
         end
         S_FAULT: begin
         end
         default: nxt_state = S_IDLE;
      endcase

      // entry actions, so outputs already match the state they are shown with
      if (nxt_state == S_LOAD && cur_state != S_LOAD) begin
         nxt_freq   = FREQ_DEFAULT;
         nxt_lg     = LG_FAST;
         nxt_locked = 1'b0;
         nxt_run    = 16'd0;
         nxt_to     = 24'd0;
         nxt_bad    = 8'd0;
         nxt_load   = 4'd0;
      end
      if (nxt_state == S_HOLD)
         nxt_locked = 1'b0;
      if (nxt_state == S_FAULT) begin
         nxt_freq   = FREQ_DEFAULT;
         nxt_locked = 1'b0;
         nxt_fault  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         cur_state     <= S_IDLE;
         freq_out      <= FREQ_DEFAULT;
         lgcoefficient <= LG_FAST;
         locked        <= 1'b0;
         fault         <= 1'b0;
         run_cnt       <= 16'd0;
         to_cnt        <= 24'd0;
         bad_cnt       <= 8'd0;
         retry         <= 3'd0;
         load_cnt      <= 4'd0;
      end else begin
         cur_state     <= nxt_state;
         freq_out      <= nxt_freq;
         lgcoefficient <= nxt_lg;
         locked        <= nxt_locked;
         fault         <= nxt_fault;
         run_cnt       <= nxt_run;
         to_cnt        <= nxt_to;
         bad_cnt       <= nxt_bad;
         retry         <= nxt_retry;
         load_cnt      <= nxt_load;
      end
   end

`ifdef PLL_LOCK_STATS_EN
   always_ff @(posedge clk) begin
      if (!nrst)
         lock_loss_cnt <= 16'd0;
      else if ((cur_state == S_TRACK) && ((nxt_state == S_LOAD) || (nxt_state == S_HOLD))
               && (lock_loss_cnt != 16'hFFFF))
         lock_loss_cnt <= lock_loss_cnt + 16'd1;
   end
`endif

endmodule
